// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: two requester ports plus data-memory control bundle
interface dmem_arbiter_if;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [2:0]  mask0, mask1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr, mem_rd;
    logic [2:0]  mem_mask;
    logic        busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mask0, mask1, mem_rdata,
        output ack0, ack1, err0, err1, rdata0, rdata1,
               mem_addr, mem_wdata, mem_wr, mem_rd, mem_mask, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mask0, mask1, mem_rdata,
        input  ack0, ack1, err0, err1, rdata0, rdata1,
               mem_addr, mem_wdata, mem_wr, mem_rd, mem_mask, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port sequencer in front of the data memory
module dmem_arbiter #(
    parameter int MEM_WORDS  = 256,
    parameter bit RESET_PRIO = 1'b0
) (
    input logic clk,
    input logic rst,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    state_t      state, state_nx;
    logic        ptr, gid, gnt, any_req, illegal, sel_we;
    logic [31:0] sel_addr, sel_wdata;
    logic [2:0]  sel_mask;

    always_comb begin
        any_req   = bus.req0 | bus.req1;
        gnt       = (bus.req0 & bus.req1) ? ptr : bus.req1;
        sel_we    = gnt ? bus.we1 : bus.we0;
        sel_addr  = gnt ? bus.addr1 : bus.addr0;
        sel_wdata = gnt ? bus.wdata1 : bus.wdata0;
        sel_mask  = gnt ? bus.mask1 : bus.mask0;
        illegal   = !(sel_mask inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                  || (sel_we && sel_mask[2])
                  || (sel_mask == 3'b010 && sel_addr[1:0] != 2'b00)
                  || (sel_mask[1:0] == 2'b01 && sel_addr[0])
                  || (sel_addr[31:2] >= 30'(MEM_WORDS));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = (state == IDLE)   ? (any_req ? (illegal ? ERR : ACCESS) : IDLE) :
                   (state == ACCESS) ? RESP : IDLE;
    end

    always_comb begin
        bus.ack0 = (state == RESP || state == ERR) && !gid;
        bus.ack1 = (state == RESP || state == ERR) && gid;
        bus.err0 = (state == ERR) && !gid;
        bus.err1 = (state == ERR) && gid;
        bus.busy = (state == ACCESS) || (state == RESP);
    end

    // Rejected requests are latched too but never assert mem_wr/mem_rd
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr           <= RESET_PRIO;
            gid           <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_mask  <= '0;
            bus.mem_wr    <= 1'b0;
            bus.mem_rd    <= 1'b0;
            bus.rdata0    <= '0;
            bus.rdata1    <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                gid           <= gnt;
                bus.mem_addr  <= sel_addr;
                bus.mem_wdata <= sel_wdata;
                bus.mem_mask  <= sel_mask;
                bus.mem_wr    <= !illegal && sel_we;
                bus.mem_rd    <= !illegal && !sel_we;
            end
            if (state == ACCESS) begin
                if (bus.mem_rd && !gid) bus.rdata0 <= bus.mem_rdata;
                if (bus.mem_rd && gid)  bus.rdata1 <= bus.mem_rdata;
                bus.mem_wr <= 1'b0;
                bus.mem_rd <= 1'b0;
            end
            if (state == RESP || state == ERR) ptr <= !gid;
        end
    end
endmodule
